muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide unit for the MIPS-style datapath. It sits directly downstream of the register file, in parallel with the ALU: it takes the two register read ports (rdA, rdB) as operands and performs MULT/MULTU/DIV/DIVU with one bit per cycle. Results go into internal HI/LO registers for later MFHI/MFLO. A start/busy/done handshake lets the control stall the pipeline while an operation is in flight.

---
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: one bit per cycle, results land in HI/LO.
// Handshake: start accepted in IDLE, busy while in flight, single-cycle done pulse.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             is_div_q, neg_q, rem_neg_q, bzero_q;
    logic [WIDTH-1:0] opa_q, opnd_q, rem_q;
    logic [W2-1:0]    acc_q;

    logic             sgn_d;
    logic [WIDTH-1:0] a_mag_d, b_mag_d;
    logic [WIDTH:0]   mul_sum_d, div_shift_d, div_trial_d;
    logic [W2-1:0]    mul_acc_d, prod_d;
    logic [WIDTH-1:0] div_rem_d, div_quo_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             dbz_d;

    // Operand magnitudes for the accept edge
    always_comb begin
        sgn_d   = ~op[0];
        a_mag_d = (sgn_d && opA[WIDTH-1]) ? (~opA + 1'b1) : opA;
        b_mag_d = (sgn_d && opB[WIDTH-1]) ? (~opB + 1'b1) : opB;
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum_d   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_d   = {mul_sum_d, acc_q[WIDTH-1:1]};
        div_shift_d = {rem_q, acc_q[WIDTH-1]};
        div_trial_d = div_shift_d - {1'b0, opnd_q};
        div_rem_d   = div_trial_d[WIDTH] ? div_shift_d[WIDTH-1:0] : div_trial_d[WIDTH-1:0];
        div_quo_d   = {acc_q[WIDTH-2:0], ~div_trial_d[WIDTH]};
    end

    // Sign correction and divide-by-zero override applied in FIX
    always_comb begin
        prod_d = neg_q ? (~acc_q + 1'b1) : acc_q;
        hi_d   = prod_d[W2-1:WIDTH];
        lo_d   = prod_d[WIDTH-1:0];
        dbz_d  = 1'b0;
        if (is_div_q) begin
            if (bzero_q) begin
                hi_d  = opa_q;
                lo_d  = '1;
                dbz_d = 1'b1;
            end else begin
                lo_d = neg_q     ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
                hi_d = rem_neg_q ? (~rem_q + 1'b1)            : rem_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            opa_q     <= '0;
            opnd_q    <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_q     <= sgn_d && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        rem_neg_q <= sgn_d && opA[WIDTH-1];
                        bzero_q   <= (opB == '0);
                        opa_q     <= opA;
                        opnd_q    <= op[1] ? b_mag_d : a_mag_d;
                        acc_q     <= {WIDTH'(0), (op[1] ? a_mag_d : b_mag_d)};
                        rem_q     <= '0;
                        count_q   <= CW'(WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= is_div_q ? {acc_q[W2-1:WIDTH], div_quo_d} : mul_acc_d;
                    rem_q   <= div_rem_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    dbz_q   <= dbz_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences,
// and random operations compared against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA, opB;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .opA(opA), .opB(opB), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [31:0] ehi, elo;
        logic        edbz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural semantics
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo, output logic mdbz);
        longint      sp, sq, sr;
        logic [63:0] up;
        mdbz = 1'b0;
        mhi  = '0;
        mlo  = '0;
        case (o)
            2'd0: begin
                sp  = longint'($signed(a)) * longint'($signed(b));
                up  = 64'(sp);
                mhi = up[63:32];
                mlo = up[31:0];
            end
            2'd1: begin
                up  = {32'd0, a} * {32'd0, b};
                mhi = up[63:32];
                mlo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    mlo  = 32'hFFFF_FFFF;
                    mhi  = a;
                    mdbz = 1'b1;
                end else if (o == 2'd2) begin
                    sq  = longint'($signed(a)) / longint'($signed(b));
                    sr  = longint'($signed(a)) % longint'($signed(b));
                    mlo = 32'(sq);
                    mhi = 32'(sr);
                end else begin
                    mlo = a / b;
                    mhi = a % b;
                end
            end
        endcase
    endfunction

    // Issue one op; optionally disturb inputs while busy. Returns latency and busy cycle count.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int lat, output int bcyc);
        lat  = 0;
        bcyc = 0;
        @(negedge clock);
        start = 1'b1; op = o; opA = a; opB = b;
        @(posedge clock); #1;
        if (busy) bcyc++;
        while (lat < 60) begin
            @(negedge clock);
            start = 1'b0;
            if (disturb && (lat == 5 || lat == 20)) begin
                start = 1'b1;
                op    = ~o;
                opA   = $urandom;
                opB   = $urandom;
            end
            if (disturb && lat == 10) begin
                opA = ~a;
                opB = b + 32'd7;
            end
            @(posedge clock); #1;
            lat++;
            if (done) break;
            if (busy) bcyc++;
        end
    endtask

    task automatic do_check(input string name, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input bit disturb);
        logic [31:0] ehi, elo;
        logic        edbz;
        int          lat, bcyc;
        model(o, a, b, ehi, elo, edbz);
        run_op(o, a, b, disturb, lat, bcyc);
        chk($sformatf("%s latency", name), 64'(lat), 64'd33);
        chk($sformatf("%s busy_cycles", name), 64'(bcyc), 64'd33);
        chk($sformatf("%s busy_at_done", name), 64'(busy), 64'd0);
        chk($sformatf("%s hi", name), 64'(hi), 64'(ehi));
        chk($sformatf("%s lo", name), 64'(lo), 64'(elo));
        chk($sformatf("%s div_by_zero", name), 64'(div_by_zero), 64'(edbz));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h8000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'd0;
            3:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        int dcnt, bcnt;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'd0, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
        vecs[2] = '{2'd0, 32'h13,        32'h1E,        32'h0,         32'h23A,       1'b0};
        vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'd3, 32'h13,        32'd4,         32'd3,         32'd4,         1'b0};
        vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        vecs[6] = '{2'd3, 32'h1E,        32'd0,         32'h1E,        32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{2'd1, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};

        reset = 1'b1; start = 1'b0; op = 2'd0; opA = '0; opB = '0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset dbz", 64'(div_by_zero), 64'd0);

        // Consecutive entries issue start in the previous op's done cycle
        for (int i = 0; i < 8; i++) begin
            logic [31:0] mhi, mlo;
            logic        mdbz;
            int          lat, bcyc;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bcyc);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
            chk($sformatf("vec%0d busy_cycles", i), 64'(bcyc), 64'd33);
            chk($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].ehi));
            chk($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].elo));
            chk($sformatf("vec%0d dbz", i), 64'(div_by_zero), 64'(vecs[i].edbz));
            model(vecs[i].op, vecs[i].a, vecs[i].b, mhi, mlo, mdbz);
            chk($sformatf("vec%0d model_hi", i), 64'(hi), 64'(mhi));
            chk($sformatf("vec%0d model_lo", i), 64'(lo), 64'(mlo));
        end

        // Starts and operand changes while busy must not disturb the op in flight
        do_check("disturb", 2'd2, 32'hFFFF_FF85, 32'd10, 1'b1);
        @(negedge clock);
        start = 1'b0;
        dcnt = 0; bcnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        chk("disturb extra_done", 64'(dcnt), 64'd0);
        chk("disturb busy_after", 64'(bcnt), 64'd0);

        // Reset mid-operation aborts with no done
        @(negedge clock);
        start = 1'b1; op = 2'd1; opA = 32'h1E; opB = 32'd4;
        @(posedge clock); #1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) dcnt++;
        end
        chk("abort no_done", 64'(dcnt), 64'd0);
        do_check("after_abort", 2'd1, 32'h1E, 32'd4, 1'b0);

        // Reset and start together: start is dropped
        @(negedge clock);
        reset = 1'b1; start = 1'b1; op = 2'd1; opA = 32'd5; opB = 32'd5;
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        @(posedge clock); #1;
        chk("reset_start busy", 64'(busy), 64'd0);

        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            do_check($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
